// File: rtl/add_pipe.sv
// add_pipe: pipelined adder/subtractor resolving one carry chunk per stage; define ADD_PIPE_FLAGS_EN to add ovf_o/zero_o
module add_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
`ifdef ADD_PIPE_FLAGS_EN
    output logic             ovf_o,
    output logic             zero_o,
`endif
    output logic             carry_o
);
    localparam int C = WIDTH / STAGES;
    localparam int L = STAGES - 1;
    logic              adv;
    logic [STAGES-1:0] v_q, c_q, in_v, in_c, co;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  in_a [STAGES];
    logic [WIDTH-1:0]  in_b [STAGES];
    logic [WIDTH-1:0]  in_s [STAGES];
    logic [WIDTH-1:0]  nsum [STAGES];
    logic [C:0]        tmp;
    assign adv     = ready_i | ~v_q[L];
    assign ready_o = adv;
    assign valid_o = v_q[L];
    assign sum_o   = s_q[L];
    assign carry_o = c_q[L];
    // feed stage 0 from the ports and stage k from stage k-1, then resolve chunk k of each stage
    always_comb begin
        in_v[0] = valid_i;
        in_a[0] = a_i;
        in_b[0] = sub_i ? ~b_i : b_i;
        in_s[0] = '0;
        in_c[0] = sub_i;
        for (int k = 1; k < STAGES; k++) begin
            in_v[k] = v_q[k-1];
            in_a[k] = a_q[k-1];
            in_b[k] = b_q[k-1];
            in_s[k] = s_q[k-1];
            in_c[k] = c_q[k-1];
        end
        tmp = '0;
        co  = '0;
        for (int k = 0; k < STAGES; k++) begin
            tmp = {1'b0, in_a[k][k*C +: C]} + {1'b0, in_b[k][k*C +: C]} + (C+1)'(in_c[k]);
            co[k] = tmp[C];
            nsum[k] = in_s[k];
            nsum[k][k*C +: C] = tmp[C-1:0];
        end
    end
    // all stages advance together; data loads only with a valid beat so bubbles keep the last result
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q <= in_v;
            for (int k = 0; k < STAGES; k++) begin
                if (in_v[k]) begin
                    a_q[k] <= in_a[k];
                    b_q[k] <= in_b[k];
                    s_q[k] <= nsum[k];
                    c_q[k] <= co[k];
                end
            end
        end
    end
`ifdef ADD_PIPE_FLAGS_EN
    // carry into the MSB is recovered as a^b^sum at the MSB and compared with the carry out
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ovf_o  <= 1'b0;
            zero_o <= 1'b0;
        end else if (adv && in_v[L]) begin
            ovf_o  <= in_a[L][WIDTH-1] ^ in_b[L][WIDTH-1] ^ nsum[L][WIDTH-1] ^ co[L];
            zero_o <= nsum[L] == '0;
        end
    end
`endif
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed vectors for add_pipe at 16/4, 16/1 and 32/8 (flags checked when ADD_PIPE_FLAGS_EN is defined)
module tb_add_pipe;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        cy;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, valid, ready_in, sub;
    logic [15:0] a, b;
    logic [31:0] a32, b32;
    logic        rdy0, vo0, cy0, rdy1, vo1, cy1, rdy2, vo2, cy2;
    logic [15:0] s0, s1;
    logic [31:0] s2;
`ifdef ADD_PIPE_FLAGS_EN
    logic        ov0, z0, ov1, z1, ov2, z2;
`endif
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          n1 = 0;
    int          n2 = 0;
    int          e;
    bit          mon = 1'b0;
    logic [15:0] obs_s[$];
    logic        obs_c[$];
    int          obs_t[$];
    vec_t        tv[8];

    add_pipe #(.WIDTH(16), .STAGES(4)) d0 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .ready_o(rdy0), .a_i(a), .b_i(b), .sub_i(sub),
        .valid_o(vo0), .ready_i(ready_in), .sum_o(s0),
`ifdef ADD_PIPE_FLAGS_EN
        .ovf_o(ov0), .zero_o(z0),
`endif
        .carry_o(cy0));
    add_pipe #(.WIDTH(16), .STAGES(1)) d1 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .ready_o(rdy1), .a_i(a), .b_i(b), .sub_i(sub),
        .valid_o(vo1), .ready_i(ready_in), .sum_o(s1),
`ifdef ADD_PIPE_FLAGS_EN
        .ovf_o(ov1), .zero_o(z1),
`endif
        .carry_o(cy1));
    add_pipe #(.WIDTH(32), .STAGES(8)) d2 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .ready_o(rdy2), .a_i(a32), .b_i(b32), .sub_i(sub),
        .valid_o(vo2), .ready_i(ready_in), .sum_o(s2),
`ifdef ADD_PIPE_FLAGS_EN
        .ovf_o(ov2), .zero_o(z2),
`endif
        .carry_o(cy2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon) begin
            if (vo0 && ready_in) begin
                obs_s.push_back(s0);
                obs_c.push_back(cy0);
                obs_t.push_back(cyc);
            end
            if (vo1 && ready_in) n1++;
            if (vo2 && ready_in) n2++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // call at posedge+1; returns at posedge+1 right after the accept edge
    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        int n = 0;
        a = av;
        b = bv;
        sub = sv;
        valid = 1'b1;
        @(negedge clk);
        while (!rdy0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", rdy0, 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_out(input int which, output int edges);
        edges = 1;
        while (!(which == 0 ? vo0 : vo2) && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic clear_obs();
        obs_s.delete();
        obs_c.delete();
        obs_t.delete();
    endtask

    task automatic check_obs(input string name, input int first, input int cnt);
        chk({name, "_count"}, obs_s.size(), cnt);
        for (int i = 0; i < cnt && i < obs_s.size(); i++) begin
            chk($sformatf("%s_sum[%0d]", name, i), obs_s[i], tv[first+i].sum);
            chk($sformatf("%s_carry[%0d]", name, i), obs_c[i], tv[first+i].cy);
            if (i > 0) chk($sformatf("%s_gap[%0d]", name, i), obs_t[i] - obs_t[i-1], 1);
        end
    endtask

    initial begin
        tv[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tv[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tv[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tv[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        tv[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        tv[6] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tv[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        rst_n = 1'b0;
        valid = 1'b0;
        ready_in = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        a32 = '0;
        b32 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", vo0, 0);
        chk("rst_sum", s0, 0);
        chk("rst_carry", cy0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_valid_w32", vo2, 0);
        chk("rst_sum_w32", s2, 0);
`ifdef ADD_PIPE_FLAGS_EN
        chk("rst_ovf", ov0, 0);
        chk("rst_zero", z0, 0);
`endif
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(tv[i].a, tv[i].b, tv[i].sub);
            chk($sformatf("s1_valid[%0d]", i), vo1, 1);
            chk($sformatf("s1_sum[%0d]", i), s1, tv[i].sum);
            chk($sformatf("s1_carry[%0d]", i), cy1, tv[i].cy);
            wait_out(0, e);
            chk($sformatf("latency[%0d]", i), e, 4);
            chk($sformatf("sum[%0d]", i), s0, tv[i].sum);
            chk($sformatf("carry[%0d]", i), cy0, tv[i].cy);
`ifdef ADD_PIPE_FLAGS_EN
            chk($sformatf("ovf[%0d]", i), ov0, tv[i].ovf);
            chk($sformatf("zero[%0d]", i), z0, tv[i].zero);
            chk($sformatf("s1_ovf[%0d]", i), ov1, tv[i].ovf);
            chk($sformatf("s1_zero[%0d]", i), z1, tv[i].zero);
`endif
            @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        clear_obs();
        mon = 1'b1;
        for (int i = 0; i < 8; i++) send(tv[i].a, tv[i].b, tv[i].sub);
        repeat (10) @(posedge clk);
        #1;
        mon = 1'b0;
        check_obs("b2b", 0, 8);
        ready_in = 1'b0;
        clear_obs();
        mon = 1'b1;
        for (int i = 0; i < 4; i++) send(tv[i].a, tv[i].b, tv[i].sub);
        a = tv[4].a;
        b = tv[4].b;
        sub = tv[4].sub;
        valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_ready[%0d]", k), rdy0, 0);
            chk($sformatf("bp_hold[%0d]", k), {vo0, cy0, s0}, {1'b1, 1'b0, 16'h8000});
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", rdy0, 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        mon = 1'b0;
        check_obs("bp", 0, 5);
        clear_obs();
        n2 = 0;
        a32 = 32'h1111_2222;
        b32 = 32'h0000_3333;
        mon = 1'b1;
        for (int i = 0; i < 3; i++) send(tv[i].a, tv[i].b, tv[i].sub);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_valid", vo0, 0);
        chk("mid_rst_sum", s0, 0);
        chk("mid_rst_carry", cy0, 0);
        chk("mid_rst_valid_w32", vo2, 0);
        chk("mid_rst_sum_w32", s2, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("mid_rst_emitted", obs_s.size(), 0);
        chk("mid_rst_emitted_w32", n2, 0);
        ready_in = 1'b0;
        n1 = 0;
        send(tv[0].a, tv[0].b, tv[0].sub);
        @(negedge clk);
        chk("s1_held_valid", vo1, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("s1_rst_valid", vo1, 0);
        chk("s1_rst_sum", s1, 0);
        ready_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        mon = 1'b0;
        chk("s1_rst_emitted", n1, 0);
        chk("s1_rst_emitted_w16", obs_s.size(), 0);
        a32 = 32'hFFFF_FFFF;
        b32 = 32'h0000_0001;
        send(16'h0, 16'h0, 1'b0);
        wait_out(2, e);
        chk("w32_latency_add", e, 8);
        chk("w32_sum_add", s2, 32'h0000_0000);
        chk("w32_carry_add", cy2, 1);
        @(posedge clk);
        #1;
        a32 = 32'h0000_0000;
        b32 = 32'h0000_0001;
        send(16'h0, 16'h0, 1'b1);
        wait_out(2, e);
        chk("w32_latency_sub", e, 8);
        chk("w32_sum_sub", s2, 32'hFFFF_FFFF);
        chk("w32_carry_sub", cy2, 0);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
